// File: rtl/cache_refill_arbiter_if.sv
// Bundle of the requester-side and AXI-controller-side signals of the
// refill arbiter. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding cache units and AXI controller.
interface cache_refill_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int NREQ       = 3
);
    // Requester side
    logic [NREQ-1:0]                 req_rreq_i;
    logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [NREQ-1:0]                 req_rdy_o;
    logic [NREQ-1:0]                 req_rvalid_o;
    logic                            req_rlast_o;
    logic [DATA_WIDTH-1:0]           req_rdata_o;

    // AXI-controller side
    logic                            axi_rreq_o;
    logic [ADDR_WIDTH-1:0]           axi_addr_o;
    logic                            axi_rdy_i;
    logic                            axi_rvalid_i;
    logic                            axi_rlast_i;
    logic [DATA_WIDTH-1:0]           axi_data_i;

    modport master (
        input  req_rreq_i, req_addr_i,
        output req_rdy_o, req_rvalid_o, req_rlast_o, req_rdata_o,
        output axi_rreq_o, axi_addr_o,
        input  axi_rdy_i, axi_rvalid_i, axi_rlast_i, axi_data_i
    );

    modport slave (
        output req_rreq_i, req_addr_i,
        input  req_rdy_o, req_rvalid_o, req_rlast_o, req_rdata_o,
        input  axi_rreq_o, axi_addr_o,
        output axi_rdy_i, axi_rvalid_i, axi_rlast_i, axi_data_i
    );
endinterface

// File: rtl/cache_refill_arbiter.sv
// Round-robin arbiter sharing the single AXI-controller read channel
// between the ICache (0), DCache (1) and uncached loads (2). One request
// is in flight at a time: its address is latched at grant, presented to
// the AXI controller until accepted, and the returned beats are steered
// combinationally back to the granted requester.
module cache_refill_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int NREQ       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_refill_arbiter_if.master bus
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last_grant;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_any_req;
    logic [GW-1:0]         w_pick;
    logic                  w_last_beat;

    // First requester set at or after last_grant+1, wrapping modulo NREQ,
    // so the most recently served requester has the lowest priority.
    function automatic logic [GW-1:0] rr_pick(
        input logic [NREQ-1:0] reqs,
        input logic [GW-1:0]   last
    );
        int   idx;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(last) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && reqs[idx]) begin
                rr_pick = GW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // Arbitration inputs: pending requests and the round-robin winner.
    always_comb begin
        w_any_req   = |bus.req_rreq_i;
        w_pick      = rr_pick(bus.req_rreq_i, r_last_grant);
        w_last_beat = bus.axi_rvalid_i & bus.axi_rlast_i;
    end

    // FSM state register; reset may arrive mid-burst, beats still in
    // flight afterwards land in IDLE and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: latch winner and its address on leaving IDLE,
    // record the finished grant for round-robin on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_addr       <= '0;
            r_last_grant <= GW'(NREQ - 1);
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant <= w_pick;
                r_addr  <= bus.req_addr_i[w_pick];
            end
            if (r_state == ST_WAIT && w_last_beat) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Next-state and output decode; every output is 0 in IDLE, which also
    // makes all outputs 0 while reset holds the FSM in IDLE.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a
        // signal unassigned, which would infer a latch.
        w_state_nxt      = r_state;
        bus.req_rdy_o    = '0;
        bus.req_rvalid_o = '0;
        bus.req_rlast_o  = 1'b0;
        bus.req_rdata_o  = '0;
        bus.axi_rreq_o   = 1'b0;
        bus.axi_addr_o   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.axi_rreq_o = 1'b1;
                bus.axi_addr_o = r_addr;
                if (bus.axi_rdy_i) begin
                    bus.req_rdy_o[r_grant] = 1'b1;
                    w_state_nxt            = ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus.req_rvalid_o[r_grant] = bus.axi_rvalid_i;
                bus.req_rlast_o           = w_last_beat;
                bus.req_rdata_o           = bus.axi_data_i;
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: single request, stray beats,
// mid-flight deassert, multi-beat burst, async reset in WAIT and
// round-robin rotation with all requesters asserting.
module tb_cache_refill_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int NR = 3;

    localparam logic [AW-1:0] ADDR0 = 32'h1C00_0040;
    localparam logic [AW-1:0] ADDR1 = 32'h2000_0080;
    localparam logic [AW-1:0] ADDR2 = 32'h3000_0200;
    localparam logic [DW-1:0] DATA_A5 = {16{8'hA5}};

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cache_refill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) bus ();

    cache_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // All outputs zero (IDLE or reset).
    task automatic check_quiet(input string tag);
        check({tag, ".rdy"},    128'(bus.req_rdy_o),    128'(0));
        check({tag, ".rvalid"}, 128'(bus.req_rvalid_o), 128'(0));
        check({tag, ".rlast"},  128'(bus.req_rlast_o),  128'(0));
        check({tag, ".rdata"},  128'(bus.req_rdata_o),  128'(0));
        check({tag, ".arreq"},  128'(bus.axi_rreq_o),   128'(0));
        check({tag, ".aaddr"},  128'(bus.axi_addr_o),   128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp_addr [4];
        int            exp_g    [4];
        n_checks = 0;
        n_errors = 0;

        rst              = 1'b1;
        bus.req_rreq_i   = '0;
        bus.req_addr_i   = '0;
        bus.axi_rdy_i    = 1'b0;
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        bus.axi_data_i   = '0;

        // ---------------- reset state
        cyc();
        cyc();
        check_quiet("reset");
        rst = 1'b0;

        // ---------------- single request, requester 0
        bus.req_rreq_i    = 3'b001;
        bus.req_addr_i[0] = ADDR0;
        #1;
        check("t1.idle_no_rreq", 128'(bus.axi_rreq_o), 128'(0));
        cyc();
        check("t1.req_rreq",  128'(bus.axi_rreq_o), 128'(1));
        check("t1.req_addr",  128'(bus.axi_addr_o), 128'(ADDR0));
        check("t1.req_nordy", 128'(bus.req_rdy_o),  128'(0));
        cyc();
        check("t1.req_addr2", 128'(bus.axi_addr_o), 128'(ADDR0));
        cyc();
        bus.axi_rdy_i  = 1'b1;
        #1;
        check("t1.rdy_pulse", 128'(bus.req_rdy_o),  128'(3'b001));
        check("t1.addr3",     128'(bus.axi_addr_o), 128'(ADDR0));
        cyc();
        bus.axi_rdy_i    = 1'b0;
        bus.req_rreq_i   = 3'b000;
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rlast_i  = 1'b1;
        bus.axi_data_i   = DATA_A5;
        #1;
        check("t1.wait_rreq", 128'(bus.axi_rreq_o),   128'(0));
        check("t1.wait_rdy",  128'(bus.req_rdy_o),    128'(0));
        check("t1.rvalid",    128'(bus.req_rvalid_o), 128'(3'b001));
        check("t1.rlast",     128'(bus.req_rlast_o),  128'(1));
        check("t1.rdata",     128'(bus.req_rdata_o),  128'(DATA_A5));
        cyc();
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        bus.axi_data_i   = '0;
        #1;
        check_quiet("t1.idle_after");

        // ---------------- stray beat in IDLE
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rlast_i  = 1'b1;
        bus.axi_data_i   = {4{32'hDEAD_BEEF}};
        #1;
        check_quiet("t6.stray_idle");
        cyc();
        check_quiet("t6.still_idle");

        // ---------------- requester 2 alone; stray in REQ; deassert in REQ
        bus.axi_rvalid_i  = 1'b0;
        bus.axi_rlast_i   = 1'b0;
        bus.req_rreq_i    = 3'b100;
        bus.req_addr_i[2] = ADDR2;
        cyc();
        check("t4.req_rreq", 128'(bus.axi_rreq_o), 128'(1));
        check("t4.req_addr", 128'(bus.axi_addr_o), 128'(ADDR2));
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rlast_i  = 1'b1;
        bus.req_rreq_i   = 3'b000;
        #1;
        check("t6.stray_req_rvalid", 128'(bus.req_rvalid_o), 128'(0));
        check("t6.stray_req_rlast",  128'(bus.req_rlast_o),  128'(0));
        check("t6.stray_req_rdata",  128'(bus.req_rdata_o),  128'(0));
        cyc();
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        #1;
        check("t6.still_req",  128'(bus.axi_rreq_o), 128'(1));
        check("t4.addr_held",  128'(bus.axi_addr_o), 128'(ADDR2));
        cyc();
        check("t4.still_req2", 128'(bus.axi_rreq_o), 128'(1));
        bus.axi_rdy_i = 1'b1;
        #1;
        check("t4.rdy_pulse", 128'(bus.req_rdy_o), 128'(3'b100));
        cyc();
        bus.axi_rdy_i    = 1'b0;
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rlast_i  = 1'b1;
        bus.axi_data_i   = 128'h0000_00D2;
        #1;
        check("t4.rvalid", 128'(bus.req_rvalid_o), 128'(3'b100));
        check("t4.rdata",  128'(bus.req_rdata_o),  128'h0000_00D2);
        cyc();
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        #1;
        check_quiet("t4.idle_after");

        // ---------------- multi-beat burst to requester 1 with a gap
        bus.req_rreq_i    = 3'b010;
        bus.req_addr_i[1] = ADDR1;
        cyc();
        check("t3.req_addr", 128'(bus.axi_addr_o), 128'(ADDR1));
        bus.axi_rdy_i = 1'b1;
        #1;
        check("t3.rdy_pulse", 128'(bus.req_rdy_o), 128'(3'b010));
        cyc();
        bus.axi_rdy_i = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus.axi_rvalid_i = (b != 2);
            bus.axi_rlast_i  = (b == 4);
            bus.axi_data_i   = 128'(32'hB000_0000 + b);
            if (b == 4) bus.req_rreq_i = 3'b000;
            #1;
            check($sformatf("t3.rvalid%0d", b), 128'(bus.req_rvalid_o), (b != 2) ? 128'(3'b010) : 128'(0));
            check($sformatf("t3.rlast%0d", b),  128'(bus.req_rlast_o),  128'(b == 4));
            cyc();
        end
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        bus.axi_data_i   = '0;
        #1;
        check_quiet("t3.idle_after");

        // ---------------- asynchronous reset in WAIT (requester 0 granted)
        bus.req_rreq_i = 3'b001;
        cyc();
        check("t5.req_addr", 128'(bus.axi_addr_o), 128'(ADDR0));
        bus.axi_rdy_i = 1'b1;
        cyc();
        bus.axi_rdy_i    = 1'b0;
        bus.req_rreq_i   = 3'b000;
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rlast_i  = 1'b0;
        bus.axi_data_i   = DATA_A5;
        #1;
        check("t5.beat_before_rst", 128'(bus.req_rvalid_o), 128'(3'b001));
        #2;
        rst = 1'b1;
        #1;
        check_quiet("t5.in_reset");
        bus.req_rreq_i    = 3'b111;
        bus.req_addr_i[0] = ADDR0;
        bus.req_addr_i[1] = ADDR1;
        bus.req_addr_i[2] = ADDR2;
        bus.axi_rlast_i   = 1'b1;
        cyc();
        check_quiet("t5.held_reset");
        rst = 1'b0;
        #1;
        check_quiet("t5.stray_after_rst");

        // ---------------- all requesting: rotation 0,1,2,0
        exp_g    = '{0, 1, 2, 0};
        exp_addr = '{ADDR0, ADDR1, ADDR2, ADDR0};
        cyc();
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #1;
            check($sformatf("t2.rreq%0d", t), 128'(bus.axi_rreq_o), 128'(1));
            check($sformatf("t2.addr%0d", t), 128'(bus.axi_addr_o), 128'(exp_addr[t]));
            bus.axi_rdy_i = 1'b1;
            #1;
            check($sformatf("t2.rdy%0d", t), 128'(bus.req_rdy_o), 128'(3'b001 << exp_g[t]));
            cyc();
            bus.axi_rdy_i    = 1'b0;
            bus.axi_rvalid_i = 1'b1;
            bus.axi_rlast_i  = 1'b1;
            bus.axi_data_i   = 128'(t + 1);
            #1;
            check($sformatf("t2.rvalid%0d", t), 128'(bus.req_rvalid_o), 128'(3'b001 << exp_g[t]));
            check($sformatf("t2.rdata%0d", t),  128'(bus.req_rdata_o),  128'(t + 1));
            cyc();
            bus.axi_rvalid_i = 1'b0;
            bus.axi_rlast_i  = 1'b0;
            #1;
            check($sformatf("t2.bubble%0d", t), 128'(bus.axi_rreq_o), 128'(0));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_arbiter.md
# cache_refill_arbiter

Shares the single AXI-controller read channel between cache refill requesters: ICache, DCache and uncached loads. It takes one refill request at a time from NREQ requesters and latches that request's address. It then drives the AXI-controller request handshake and routes the returned beats back to the granted requester. Grants are round-robin, so neither cache can starve the other. The block sits between the cache/uncache units and the AXI controller, replacing their direct connection.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 128, beat width (one ICache line per beat)
- NREQ, 3, number of requesters; index 0 = ICache, 1 = DCache, 2 = uncached

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_rreq_i  in  NREQ  per-requester read request, level
- req_addr_i  in  NREQ×ADDR_WIDTH  per-requester address; sampled at grant
- req_rdy_o  out  NREQ  one-hot pulse: downstream accepted the granted request
- req_rvalid_o  out  NREQ  one-hot: data beat valid for that requester
- req_rlast_o  out  1  current beat is the last of the burst
- req_rdata_o  out  DATA_WIDTH  beat data, broadcast to all requesters
- axi_rreq_o  out  1  read request to AXI controller
- axi_addr_o  out  ADDR_WIDTH  read address to AXI controller
- axi_rdy_i  in  1  AXI controller accepts the request
- axi_rvalid_i  in  1  data beat valid
- axi_rlast_i  in  1  last beat
- axi_data_i  in  DATA_WIDTH  beat data

## Operation
- Registered state: FSM {IDLE, REQ, WAIT}, grant index g, latched address addr_r, and last_grant.
- IDLE:
  - If any req_rreq_i bit is set, select the first set index searching upward from last_grant+1, modulo NREQ.
  - Latch g and addr_r from that requester's req_addr_i, then go to REQ.
  - If no request is set, stay in IDLE.
- REQ:
  - axi_rreq_o=1 and axi_addr_o=addr_r.
  - When axi_rdy_i=1, req_rdy_o[g]=1 in that cycle and the next state is WAIT. Otherwise stay in REQ, holding the address stable.
- WAIT:
  - axi_rreq_o=0.
  - req_rvalid_o[g]=axi_rvalid_i, req_rlast_o=axi_rvalid_i&axi_rlast_i, req_rdata_o=axi_data_i, all combinational pass-through.
  - When axi_rvalid_i and axi_rlast_i are both 1, set last_grant←g and go to IDLE.
- Request commitment: once granted, a request runs to completion. Deasserting req_rreq_i[g] in REQ or WAIT does not cancel it.
  - The requester must drop req_rreq_i no later than the cycle it sees its last beat.
  - A request still high in the IDLE cycle after completion is treated as a new request.
- Ungranted requesters are never stalled or signalled; their req_rreq_i simply stays pending.
- Stray beats: axi_rvalid_i in IDLE or REQ is ignored; no req_rvalid_o is raised and the state does not change.
- req_rdata_o is 0 outside WAIT. axi_addr_o is 0 outside REQ.
- Reset (asynchronous, any state including mid-burst):
  - FSM←IDLE, g←0, addr_r←0, last_grant←NREQ-1, so requester 0 wins first.
  - All outputs are 0 while rst is high.
  - Beats in flight at reset are discarded by the stray-beat rule.

## Timing
- Request-to-downstream latency: a req_rreq_i sampled in IDLE on cycle N gives axi_rreq_o=1 on cycle N+1.
- Request phase: REQ lasts ≥1 cycle, until the cycle axi_rdy_i is seen.
- Data path: zero-cycle pass-through from axi_* to req_* in WAIT.
- Turnaround: the cycle after the last beat is IDLE, so the next grant's axi_rreq_o rises ≥2 cycles after the previous rlast. Back-to-back requests therefore have one idle bubble.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,2,0,… Any pending request is granted within NREQ-1 other transactions.

## Test plan
- Single request:
  - Stimulus: req_rreq_i=001, addr 0x1C00_0040; axi_rdy_i rises 2 cycles after axi_rreq_o; one beat with rlast, data 0xA5…A5.
  - Required response: axi_addr_o=0x1C00_0040 held stable through REQ; req_rdy_o=001 pulses once; req_rvalid_o=001 with data 0xA5…A5 and req_rlast_o=1; IDLE on the next cycle.
- Simultaneous requests:
  - Stimulus: req_rreq_i=111 held from reset; each transaction completes in one beat.
  - Required response: grant order 0,1,2,0; each axi_addr_o matches its requester.
- Multi-beat burst:
  - Stimulus: grant requester 1; 4 beats, rlast on beat 4, with a 1-cycle rvalid gap after beat 2.
  - Required response: exactly 4 req_rvalid_o=010 pulses; req_rlast_o only on the 4th; FSM stays in WAIT through the gap.
- Requester deasserts mid-flight:
  - Stimulus: requester 2 granted, drops req_rreq_i in REQ.
  - Required response: axi_rreq_o stays high until axi_rdy_i; the beat is still delivered on req_rvalid_o[2].
- Asynchronous reset in WAIT:
  - Stimulus: assert rst between clock edges during a burst; then release and send a stray axi_rvalid_i.
  - Required response: all outputs 0 immediately; after release, the stray beat is ignored and the next grant goes to requester 0.
- Stray beat in IDLE and REQ:
  - Stimulus: axi_rvalid_i=1 while in IDLE, then while in REQ.
  - Required response: req_rvalid_o stays 000 and the FSM does not change state.
